// File: rtl/bin_packetizer_if.sv
// Byte-wide AXI-Stream link from bin_packetizer toward the UDP/Ethernet framer.
interface bin_packetizer_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/bin_packetizer.sv
// Ping-pong frame capture and byte serialiser for the bin-averaging channelizer.
// Define BIN_PKT_SEQ_HDR_EN to lead each packet with a 32-bit sequence number.
module bin_packetizer #(
    parameter int BINS  = 4,
    parameter int N     = 16,
    parameter int N_out = 8
) (
    input  logic                         clk,
    input  logic                         arest_n,
    input  logic                         valid,
    input  logic [BINS*N/N_out-1:0][7:0] in_data,
    bin_packetizer_if.master             m,
    output logic [15:0]                  drop_cnt
);
    localparam int BYTES = BINS * N / N_out;
    localparam int CNT_W = (BYTES > 4) ? $clog2(BYTES) : 2;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES - 1);

`ifdef BIN_PKT_SEQ_HDR_EN
    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
    localparam state_t FIRST = HDR;
    localparam logic [1:0] HDR_LAST = 2'd3;
`else
    typedef enum logic [1:0] {IDLE, PAY} state_t;
    localparam state_t FIRST = PAY;
`endif

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [1:0]            full, full_nxt;
    logic                  wr_ptr, rd_ptr, rd_nxt;
    logic [BYTES-1:0][7:0] frame_a, frame_b, frame_sel;
    logic                  xfer, done, wr_free, capture, drop;
    logic [7:0]            byte_nxt;
    logic                  last_nxt;
`ifdef BIN_PKT_SEQ_HDR_EN
    logic [31:0]           seq, seq_nxt;
`endif

    assign xfer = m.tvalid & m.tready;

    always_ff @(posedge clk or negedge arest_n) begin
        if (!arest_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rd_nxt    = rd_ptr;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (full[rd_ptr]) begin
                    state_nxt = FIRST;
                    cnt_nxt   = '0;
                end
            end
`ifdef BIN_PKT_SEQ_HDR_EN
            HDR: begin
                if (xfer) begin
                    if (cnt[1:0] == HDR_LAST) begin
                        state_nxt = PAY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
`endif
            PAY: begin
                if (xfer) begin
                    if (cnt == LAST_IDX) begin
                        // Other buffer already full: chain straight into the next packet.
                        done      = 1'b1;
                        rd_nxt    = ~rd_ptr;
                        cnt_nxt   = '0;
                        state_nxt = full[~rd_ptr] ? FIRST : IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // A buffer released by this cycle's final handshake may take this cycle's frame.
    always_comb begin
        wr_free  = ~full[wr_ptr] | (done & (wr_ptr == rd_ptr));
        capture  = valid & wr_free;
        drop     = valid & ~wr_free;
        full_nxt = full;
        if (done)
            full_nxt[rd_ptr] = 1'b0;
        if (capture)
            full_nxt[wr_ptr] = 1'b1;
    end

`ifdef BIN_PKT_SEQ_HDR_EN
    assign seq_nxt = done ? seq + 32'd1 : seq;
`endif

    always_ff @(posedge clk or negedge arest_n) begin
        if (!arest_n) begin
            full     <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            drop_cnt <= '0;
`ifdef BIN_PKT_SEQ_HDR_EN
            seq      <= '0;
`endif
        end else begin
            full   <= full_nxt;
            rd_ptr <= rd_nxt;
            if (capture)
                wr_ptr <= ~wr_ptr;
            if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
`ifdef BIN_PKT_SEQ_HDR_EN
            seq <= seq_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            if (wr_ptr)
                frame_b <= in_data;
            else
                frame_a <= in_data;
        end
    end

    // Output byte is chosen from next-cycle state so that data and last are registered.
    always_comb begin
        frame_sel = rd_nxt ? frame_b : frame_a;
        byte_nxt  = 8'h00;
        last_nxt  = 1'b0;
        if (state_nxt == PAY) begin
            byte_nxt = frame_sel[cnt_nxt];
            last_nxt = (cnt_nxt == LAST_IDX);
        end
`ifdef BIN_PKT_SEQ_HDR_EN
        if (state_nxt == HDR) begin
            case (cnt_nxt[1:0])
                2'd0:    byte_nxt = seq_nxt[31:24];
                2'd1:    byte_nxt = seq_nxt[23:16];
                2'd2:    byte_nxt = seq_nxt[15:8];
                default: byte_nxt = seq_nxt[7:0];
            endcase
        end
`endif
    end

    always_ff @(posedge clk or negedge arest_n) begin
        if (!arest_n) begin
            m.tvalid <= 1'b0;
            m.tdata  <= 8'h00;
            m.tlast  <= 1'b0;
        end else begin
            m.tvalid <= (state_nxt != IDLE);
            m.tdata  <= byte_nxt;
            m.tlast  <= last_nxt;
        end
    end
endmodule

// File: tb/tb_bin_packetizer.sv
// Self-checking bench for bin_packetizer: directed steps plus random traffic against a queue model.
module tb_bin_packetizer;
    localparam int BINS  = 4;
    localparam int N     = 16;
    localparam int N_OUT = 8;
    localparam int BYTES = BINS * N / N_OUT;
`ifdef BIN_PKT_SEQ_HDR_EN
    localparam int HDR_LEN = 4;
`else
    localparam int HDR_LEN = 0;
`endif
    localparam int PKT_LEN = BYTES + HDR_LEN;

    typedef logic [BYTES-1:0][7:0] frame_t;

    logic        clk     = 1'b0;
    logic        arest_n = 1'b0;
    logic        valid   = 1'b0;
    frame_t      in_data = '0;
    logic [15:0] drop_cnt;

    bin_packetizer_if m_if();

    bin_packetizer #(.BINS(BINS), .N(N), .N_out(N_OUT)) dut (
        .clk      (clk),
        .arest_n  (arest_n),
        .valid    (valid),
        .in_data  (in_data),
        .m        (m_if),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < BYTES; i++)
            f[i] = 8'($urandom);
        return f;
    endfunction

    // Reference model: every accepted frame becomes a list of expected bytes; at most
    // two frames may be outstanding, and a frame finishing on an edge frees its slot
    // for a strobe on that same edge. The k-th frame accepted since reset carries seq k.
    logic [8:0]  exp_q[$];
    int          pend     = 0;
    int          mdrops   = 0;
    logic [31:0] mseq     = '0;
    bit          exp_tv   = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data;
    logic        prev_last;
    bit          mon_done;
    logic [8:0]  ent;

    always @(negedge clk) begin
        if (!arest_n) begin
            chk("rst_tvalid", m_if.tvalid, 0);
            chk("rst_tdata", m_if.tdata, 0);
            chk("rst_tlast", m_if.tlast, 0);
            chk("rst_drop", drop_cnt, 0);
            exp_q.delete();
            pend       = 0;
            mdrops     = 0;
            mseq       = '0;
            exp_tv     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            mon_done = 1'b0;
            chk("tvalid", m_if.tvalid, exp_tv);
            chk("drop_cnt", drop_cnt, mdrops);
            if (prev_stall) begin
                chk("stall_tdata", m_if.tdata, prev_data);
                chk("stall_tlast", m_if.tlast, prev_last);
            end
            if (m_if.tvalid && m_if.tready) begin
                chk("byte_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    ent = exp_q.pop_front();
                    chk("tdata", m_if.tdata, ent[7:0]);
                    chk("tlast", m_if.tlast, ent[8]);
                    mon_done = ent[8];
                end
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
            prev_last  = m_if.tlast;
            if (mon_done)
                pend--;
            exp_tv = (pend > 0);
            if (valid) begin
                if (pend < 2) begin
                    if (HDR_LEN > 0) begin
                        exp_q.push_back({1'b0, mseq[31:24]});
                        exp_q.push_back({1'b0, mseq[23:16]});
                        exp_q.push_back({1'b0, mseq[15:8]});
                        exp_q.push_back({1'b0, mseq[7:0]});
                    end
                    for (int i = 0; i < BYTES; i++)
                        exp_q.push_back({(i == BYTES - 1), in_data[i]});
                    mseq = mseq + 32'd1;
                    pend++;
                end else if (mdrops != 65535) begin
                    mdrops++;
                end
            end
        end
    end

    task automatic send(input frame_t f);
        valid   = 1'b1;
        in_data = f;
        @(posedge clk);
        #1;
        valid   = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, (n < 400), 1);
    endtask

    initial begin
        frame_t f;
        int     d0;
        m_if.tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tvalid", m_if.tvalid, 0);
        chk("reset_tdata", m_if.tdata, 0);
        chk("reset_tlast", m_if.tlast, 0);
        chk("reset_drop", drop_cnt, 0);
        arest_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frame 00..07 and first-byte latency
        for (int i = 0; i < BYTES; i++)
            f[i] = 8'(i);
        send(f);
        chk("lat_edge_k", m_if.tvalid, 0);
        @(posedge clk);
        #1;
        chk("lat_edge_k1", m_if.tvalid, 1);
        chk("first_byte", m_if.tdata, (HDR_LEN > 0) ? 8'h00 : f[0]);
        drain("drain_single");

        // Three frames at the lossless period
        for (int k = 0; k < 3; k++) begin
            send(rand_frame());
            repeat (PKT_LEN - 1) @(posedge clk);
            #1;
        end
        drain("drain_three");
        chk("three_drop", drop_cnt, 0);

        // Four strobes while stalled: two buffered, two dropped, then back-to-back
        m_if.tready = 1'b0;
        for (int k = 0; k < 4; k++)
            send(rand_frame());
        chk("stall_drop2", drop_cnt, 2);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_held", m_if.tvalid, 1);
        m_if.tready = 1'b1;
        drain("drain_stall");

        // Random ready and strobes
        for (int c = 0; c < 400; c++) begin
            m_if.tready = 1'($urandom);
            valid       = ($urandom_range(0, 5) == 0);
            in_data     = rand_frame();
            @(posedge clk);
            #1;
        end
        valid       = 1'b0;
        m_if.tready = 1'b1;
        drain("drain_random");

        // Both full, final handshake coincides with a strobe
        m_if.tready = 1'b0;
        send(rand_frame());
        send(rand_frame());
        repeat (3) @(posedge clk);
        #1;
        chk("both_full_tvalid", m_if.tvalid, 1);
        d0 = mdrops;
        m_if.tready = 1'b1;
        repeat (PKT_LEN - 1) @(posedge clk);
        #1;
        send(rand_frame());
        chk("same_cycle_no_drop", drop_cnt, d0);
        drain("drain_same_cycle");

        // Reset in the middle of a payload
        send(rand_frame());
        repeat (HDR_LEN + 3) @(posedge clk);
        #1;
        chk("mid_pkt_tvalid", m_if.tvalid, 1);
        arest_n = 1'b0;
        #1;
        chk("async_tvalid", m_if.tvalid, 0);
        chk("async_drop", drop_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        arest_n = 1'b1;
        @(posedge clk);
        #1;
        send(rand_frame());
        @(posedge clk);
        #1;
        chk("restart_first", m_if.tdata, (HDR_LEN > 0) ? 8'h00 : in_data[0]);
        drain("drain_restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
